// File: rtl/regfile_datamem_unit_pkg.sv
// Shared widths and word/address types for the datapath storage block.
package regfile_datamem_unit_pkg;

    // Default geometry: 8-bit words, 16-entry arrays.
    localparam int unsigned DFLT_DATA_W = 8;
    localparam int unsigned DFLT_ADDR_W = 4;
    localparam int unsigned DFLT_DEPTH  = 1 << DFLT_ADDR_W;

    typedef logic [DFLT_DATA_W-1:0] word_t;
    typedef logic [DFLT_ADDR_W-1:0] addr_t;

endpackage : regfile_datamem_unit_pkg

// File: rtl/regfile_datamem_unit_data_mem.sv
// Single-port data memory: asynchronous read, synchronous write and clear.
module regfile_datamem_unit_data_mem
    import regfile_datamem_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DFLT_DATA_W,
    parameter int unsigned ADDR_W = DFLT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear wins over a pending write; otherwise store on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[addr] <= wd;
        end
    end

    // Read shows stored contents only, so a same-address write appears after the edge.
    assign rd = mem[addr];

endmodule : regfile_datamem_unit_data_mem

// File: rtl/regfile_datamem_unit.sv
// Datapath storage: 2R1W register file plus a single-port data memory.
module regfile_datamem_unit
    import regfile_datamem_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DFLT_DATA_W,
    parameter int unsigned ADDR_W = DFLT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_ra1,
    input  logic [ADDR_W-1:0] rf_ra2,
    input  logic [ADDR_W-1:0] rf_wa,
    input  logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] rf_rd1,
    output logic [DATA_W-1:0] rf_rd2,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wd,
    output logic [DATA_W-1:0] dm_rd
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Every entry is an ordinary register; entry 0 is not tied to zero.
    logic [DATA_W-1:0] regs [DEPTH];

    // Register file update: clear overrides write, single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (rf_we) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    // Two independent combinational read ports, no write bypass.
    assign rf_rd1 = regs[rf_ra1];
    assign rf_rd2 = regs[rf_ra2];

    // Data memory is fully independent of the register file.
    regfile_datamem_unit_data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .reset (reset),
        .we    (dm_we),
        .addr  (dm_addr),
        .wd    (dm_wd),
        .rd    (dm_rd)
    );

endmodule : regfile_datamem_unit

// File: tb/tb_regfile_datamem_unit.sv
// Self-checking bench: directed plan followed by random traffic against an array model.
module tb_regfile_datamem_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       rf_we;
    logic [3:0] rf_ra1, rf_ra2, rf_wa;
    logic [7:0] rf_wd, rf_rd1, rf_rd2;
    logic       dm_we;
    logic [3:0] dm_addr;
    logic [7:0] dm_wd, dm_rd;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rf_m [16];
    logic [7:0] dm_m [16];

    always #5 clk = ~clk;

    regfile_datamem_unit dut (
        .clk     (clk),
        .reset   (reset),
        .rf_we   (rf_we),
        .rf_ra1  (rf_ra1),
        .rf_ra2  (rf_ra2),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .rf_rd1  (rf_rd1),
        .rf_rd2  (rf_rd2),
        .dm_we   (dm_we),
        .dm_addr (dm_addr),
        .dm_wd   (dm_wd),
        .dm_rd   (dm_rd)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    // One rising edge; the model applies the storage rules to the inputs held across it.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                rf_m[i] = 8'h00;
                dm_m[i] = 8'h00;
            end
        end else begin
            if (rf_we) rf_m[rf_wa] = rf_wd;
            if (dm_we) dm_m[dm_addr] = dm_wd;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0;
        rf_we = 1'b0;
        dm_we = 1'b0;
    endtask

    // Read back every address of both arrays against the model.
    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            rf_ra1  = 4'(i);
            rf_ra2  = 4'(15 - i);
            dm_addr = 4'(i);
            #1;
            check($sformatf("%s_rd1[%0d]", tag, i), rf_rd1, rf_m[i]);
            check($sformatf("%s_rd2[%0d]", tag, 15 - i), rf_rd2, rf_m[15 - i]);
            check($sformatf("%s_dm[%0d]", tag, i), dm_rd, dm_m[i]);
        end
    endtask

    initial begin
        idle();
        rf_ra1 = '0; rf_ra2 = '0; rf_wa = '0; rf_wd = '0;
        dm_addr = '0; dm_wd = '0;
        for (int i = 0; i < 16; i++) begin
            rf_m[i] = 8'hxx;
            dm_m[i] = 8'hxx;
        end
        #2;

        // Initial reset, then everything reads zero.
        reset = 1'b1;
        tick();
        idle();
        check_all("por");

        // Reset clear overriding simultaneous writes.
        rf_we = 1'b1; rf_wa = 4'd3; rf_wd = 8'hAA;
        dm_we = 1'b1; dm_addr = 4'd5; dm_wd = 8'hAA;
        tick();
        idle();
        rf_ra1 = 4'd3; #1;
        check("pre_reset_rf3", rf_rd1, 8'hAA);
        check("pre_reset_dm5", dm_rd, 8'hAA);
        reset = 1'b1;
        rf_we = 1'b1; rf_wa = 4'd3; rf_wd = 8'h55;
        dm_we = 1'b1; dm_addr = 4'd5; dm_wd = 8'h55;
        tick();
        idle();
        rf_ra1 = 4'd3; dm_addr = 4'd5; #1;
        check("reset_rf3", rf_rd1, 8'h00);
        check("reset_dm5", dm_rd, 8'h00);

        // Register write on successive edges, dual read, same-register read.
        rf_we = 1'b1; rf_wa = 4'd1; rf_wd = 8'h12;
        tick();
        rf_wa = 4'd2; rf_wd = 8'h34;
        tick();
        idle();
        rf_ra1 = 4'd1; rf_ra2 = 4'd2; #1;
        check("dual_rd1", rf_rd1, 8'h12);
        check("dual_rd2", rf_rd2, 8'h34);
        rf_ra1 = 4'd2; #1;
        check("same_rd1", rf_rd1, 8'h34);
        check("same_rd2", rf_rd2, 8'h34);

        // Read-during-write: old value before the edge, new value after it.
        rf_we = 1'b1; rf_wa = 4'd4; rf_wd = 8'h10;
        dm_we = 1'b1; dm_addr = 4'd7; dm_wd = 8'h10;
        tick();
        rf_ra1 = 4'd4; rf_wd = 8'h99; dm_wd = 8'h99; #1;
        check("rdw_rf_old", rf_rd1, 8'h10);
        check("rdw_dm_old", dm_rd, 8'h10);
        tick();
        check("rdw_rf_new", rf_rd1, 8'h99);
        check("rdw_dm_new", dm_rd, 8'h99);
        idle();

        // Write enables low: nothing changes over several edges.
        rf_wa = 4'd6; rf_wd = 8'hFF; dm_addr = 4'd6; dm_wd = 8'hFF;
        for (int k = 0; k < 3; k++) tick();
        rf_ra1 = 4'd6; #1;
        check("gate_rf6", rf_rd1, 8'h00);
        check("gate_dm6", dm_rd, 8'h00);

        // Full sweep including addresses 0 and 15.
        rf_we = 1'b1; dm_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rf_wa = 4'(i); rf_wd = 8'(i * 3);
            dm_addr = 4'(i); dm_wd = 8'hF0 ^ 8'(i);
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            rf_ra1 = 4'(i); dm_addr = 4'(i); #1;
            check($sformatf("sweep_rf[%0d]", i), rf_rd1, 8'(i * 3));
            check($sformatf("sweep_dm[%0d]", i), dm_rd, 8'hF0 ^ 8'(i));
        end

        // Concurrent writes to the same index in both arrays.
        rf_we = 1'b1; rf_wa = 4'd9; rf_wd = 8'h5A;
        dm_we = 1'b1; dm_addr = 4'd9; dm_wd = 8'hA5;
        tick();
        idle();
        rf_ra2 = 4'd9; #1;
        check("conc_rf9", rf_rd2, 8'h5A);
        check("conc_dm9", dm_rd, 8'hA5);
        check_all("post_directed");

        // Random traffic with occasional reset, checked around every edge.
        for (int n = 0; n < 300; n++) begin
            reset   = ($urandom_range(0, 39) == 0);
            rf_we   = 1'($urandom_range(0, 1));
            dm_we   = 1'($urandom_range(0, 1));
            rf_ra1  = 4'($urandom);
            rf_ra2  = 4'($urandom);
            rf_wa   = 4'($urandom);
            rf_wd   = 8'($urandom);
            dm_addr = 4'($urandom);
            dm_wd   = 8'($urandom);
            #1;
            check($sformatf("rnd_pre_rd1_%0d", n), rf_rd1, rf_m[rf_ra1]);
            check($sformatf("rnd_pre_rd2_%0d", n), rf_rd2, rf_m[rf_ra2]);
            check($sformatf("rnd_pre_dm_%0d", n), dm_rd, dm_m[dm_addr]);
            tick();
            check($sformatf("rnd_post_rd1_%0d", n), rf_rd1, rf_m[rf_ra1]);
            check($sformatf("rnd_post_rd2_%0d", n), rf_rd2, rf_m[rf_ra2]);
            check($sformatf("rnd_post_dm_%0d", n), dm_rd, dm_m[dm_addr]);
        end
        idle();
        check_all("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_datamem_unit
